bsg_manycore_vcache_dma_arbiter: RTL

- Multi-channel successor on the vcache DMA side: shares one memory-side DMA channel among num_cache_p bsg_cache DMA interfaces.
- Arbitrates DMA packets round-robin and forwards write-back data from the granted cache.
- Steers returning fill data to the requesting cache, in packet order, using an internal id FIFO.
- Sits between a row of vcaches and the off-chip memory / bsg_cache_to_dram controller.

---
 rtl/bsg_manycore_vcache_pkg.sv | 18 +
 rtl/bsg_manycore_vcache_dma_resp_steer.sv | 73 +++++++
 rtl/bsg_manycore_vcache_dma_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_vcache_pkg.sv
// Shared types and sizing helpers for the vcache DMA arbiter.
package bsg_manycore_vcache_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    function automatic int beats_f(input int block_words, input int data_w, input int dma_w);
        return block_words * data_w / dma_w;
    endfunction

    // DMA packet layout, MSB first: {write_not_read, addr}
    function automatic int dma_pkt_width_f(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bsg_manycore_vcache_dma_resp_steer.sv
// Fill-data steering: FIFO of requesting cache ids, per-packet beat counter and
// valid demux toward the cache at the head of the FIFO.
module bsg_manycore_vcache_dma_resp_steer #(
    parameter int num_cache_p      = 4,
    parameter int dma_data_width_p = 32,
    parameter int els_p            = 4,
    parameter int beats_p          = 8,
    parameter int id_width_p       = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   push_v,
    input  logic [id_width_p-1:0]                  push_id,
    output logic                                   full,
    input  logic [dma_data_width_p-1:0]            mem_data,
    input  logic                                   mem_data_v,
    output logic                                   mem_data_ready,
    output logic [num_cache_p*dma_data_width_p-1:0] dma_data,
    output logic [num_cache_p-1:0]                 dma_data_v,
    input  logic [num_cache_p-1:0]                 dma_data_ready
);

    localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w  = $clog2(els_p + 1);
    localparam int beat_w = (beats_p > 1) ? $clog2(beats_p) : 1;
    localparam logic [ptr_w-1:0]  last_ptr  = ptr_w'(els_p - 1);
    localparam logic [beat_w-1:0] last_beat = beat_w'(beats_p - 1);

    logic [id_width_p-1:0] ids [els_p];
    logic [ptr_w-1:0]      rd_ptr, wr_ptr;
    logic [cnt_w-1:0]      count;
    logic [beat_w-1:0]     beat;
    logic [id_width_p-1:0] head;
    logic                  empty, hs, pop;

    assign empty = (count == '0);
    assign full  = (count == cnt_w'(els_p));
    assign head  = ids[rd_ptr];

    assign mem_data_ready = ~empty & dma_data_ready[head];
    assign hs             = mem_data_v & mem_data_ready;
    assign pop            = hs & (beat == last_beat);
    assign dma_data       = {num_cache_p{mem_data}};

    always_comb begin
        dma_data_v = '0;
        for (int i = 0; i < num_cache_p; i++)
            dma_data_v[i] = mem_data_v & ~empty & (head == id_width_p'(i));
    end

    always_ff @(posedge clk_i) begin
        if (push_v) ids[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            beat   <= '0;
        end else begin
            if (push_v) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            if (pop)    rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            case ({push_v, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (hs) beat <= pop ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_manycore_vcache_dma_arbiter.sv
// Shares one memory DMA channel among num_cache_p vcache DMA ports.
// Optional per-cache grant counters: BSG_MANYCORE_VCACHE_DMA_ARBITER_STATS_EN.
module bsg_manycore_vcache_dma_arbiter
    import bsg_manycore_vcache_pkg::*;
#(
    parameter int num_cache_p           = 4,
    parameter int addr_width_p          = 28,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int dma_data_width_p      = 32,
    parameter int read_fifo_els_p       = 4,
    localparam int beats_lp     = beats_f(block_size_in_words_p, data_width_p, dma_data_width_p),
    localparam int id_width_lp  = (num_cache_p > 1) ? $clog2(num_cache_p) : 1,
    localparam int pkt_width_lp = dma_pkt_width_f(addr_width_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_cache_p*pkt_width_lp-1:0]     dma_pkt_i,
    input  logic [num_cache_p-1:0]                  dma_pkt_v_i,
    output logic [num_cache_p-1:0]                  dma_pkt_yumi_o,
    output logic [num_cache_p*dma_data_width_p-1:0] dma_data_o,
    output logic [num_cache_p-1:0]                  dma_data_v_o,
    input  logic [num_cache_p-1:0]                  dma_data_ready_i,
    input  logic [num_cache_p*dma_data_width_p-1:0] dma_data_i,
    input  logic [num_cache_p-1:0]                  dma_data_v_i,
    output logic [num_cache_p-1:0]                  dma_data_yumi_o,
    output logic [pkt_width_lp-1:0]                 mem_pkt_o,
    output logic [id_width_lp-1:0]                  mem_pkt_id_o,
    output logic                                    mem_pkt_v_o,
    input  logic                                    mem_pkt_yumi_i,
    input  logic [dma_data_width_p-1:0]             mem_data_i,
    input  logic                                    mem_data_v_i,
    output logic                                    mem_data_ready_o,
    output logic [dma_data_width_p-1:0]             mem_data_o,
    output logic                                    mem_data_v_o,
    input  logic                                    mem_data_yumi_i,
    output logic [num_cache_p*32-1:0]               stat_o
);

    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_width_lp-1:0] wr_last_lp = cnt_width_lp'(beats_lp - 1);
    localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(num_cache_p - 1);

    typedef struct packed {
        logic                    write_not_read;
        logic [addr_width_p-1:0] addr;
    } dma_pkt_s;

    dma_pkt_s [num_cache_p-1:0]                        pkts;
    logic [num_cache_p-1:0][dma_data_width_p-1:0]      wdata;
    state_e                                            state_r, state_n;
    logic [id_width_lp-1:0]                            rr_ptr_r, winner, wr_id_r;
    logic [cnt_width_lp-1:0]                           wr_cnt_r;
    logic [num_cache_p-1:0]                            req;
    logic                                              found, grant, push_v, fifo_full;
    int                                                scan;

    assign pkts  = dma_pkt_i;
    assign wdata = dma_data_i;

    // Reads need an id FIFO slot; writes never do.
    always_comb begin
        req = '0;
        for (int i = 0; i < num_cache_p; i++)
            req[i] = dma_pkt_v_i[i] & (pkts[i].write_not_read | ~fifo_full);
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = 0;
        for (int k = 0; k < num_cache_p; k++) begin
            scan = int'(rr_ptr_r) + k;
            if (scan >= num_cache_p) scan = scan - num_cache_p;
            if (!found && req[scan]) begin
                found  = 1'b1;
                winner = id_width_lp'(scan);
            end
        end
    end

    assign mem_pkt_o    = pkts[winner];
    assign mem_pkt_id_o = winner;
    assign mem_data_o   = wdata[wr_id_r];
    assign push_v       = grant & ~pkts[winner].write_not_read;

    always_comb begin
        state_n         = state_r;
        mem_pkt_v_o     = 1'b0;
        grant           = 1'b0;
        dma_pkt_yumi_o  = '0;
        mem_data_v_o    = 1'b0;
        dma_data_yumi_o = '0;
        case (state_r)
            IDLE: begin
                mem_pkt_v_o = found;
                grant       = found & mem_pkt_yumi_i;
                if (grant) begin
                    dma_pkt_yumi_o[winner] = 1'b1;
                    if (pkts[winner].write_not_read) state_n = WRITE;
                end
            end
            WRITE: begin
                mem_data_v_o             = dma_data_v_i[wr_id_r];
                dma_data_yumi_o[wr_id_r] = mem_data_yumi_i;
                if (mem_data_yumi_i && wr_cnt_r == wr_last_lp) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            wr_id_r  <= '0;
            wr_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (grant) begin
                rr_ptr_r <= (winner == last_id_lp) ? '0 : winner + 1'b1;
                if (pkts[winner].write_not_read) begin
                    wr_id_r  <= winner;
                    wr_cnt_r <= '0;
                end
            end else if (state_r == WRITE && mem_data_yumi_i) begin
                wr_cnt_r <= (wr_cnt_r == wr_last_lp) ? '0 : wr_cnt_r + 1'b1;
            end
        end
    end

    bsg_manycore_vcache_dma_resp_steer #(
        .num_cache_p     (num_cache_p),
        .dma_data_width_p(dma_data_width_p),
        .els_p           (read_fifo_els_p),
        .beats_p         (beats_lp),
        .id_width_p      (id_width_lp)
    ) resp_steer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .push_v        (push_v),
        .push_id       (winner),
        .full          (fifo_full),
        .mem_data      (mem_data_i),
        .mem_data_v    (mem_data_v_i),
        .mem_data_ready(mem_data_ready_o),
        .dma_data      (dma_data_o),
        .dma_data_v    (dma_data_v_o),
        .dma_data_ready(dma_data_ready_i)
    );

`ifdef BSG_MANYCORE_VCACHE_DMA_ARBITER_STATS_EN
    logic [num_cache_p-1:0][31:0] stat_r;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_cache_p; i++) begin
            if (reset_i)
                stat_r[i] <= '0;
            else if (grant && winner == id_width_lp'(i) && stat_r[i] != '1)
                stat_r[i] <= stat_r[i] + 1'b1;
        end
    end

    assign stat_o = stat_r;
`else
    assign stat_o = '0;
`endif

endmodule
